cpu_gen2: RTL
=============

# cpu_gen2

Parametrised multicycle processor, the next generation of the team's 16-bit bus CPU. It has a configurable data width and register count, an asynchronous-reset register file, and an ALU with a zero flag. It adds a conditional move and optional logic ops. The block is the top of the processor datapath: it accepts instructions and immediates on `dataIn`, drives the internal bus onto `dataOut`, and flags instruction completion on `done`.

## Interface
- `DW`, 16: data/bus width; must satisfy DW ≥ 3 + 2·RW.
- `NREG`, 8: register count, power of two, 2..16; RW = clog2(NREG).
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `Run` in 1: instruction-valid strobe, sampled only in T0.
- `dataIn` in DW: instruction word in T0, immediate operand in T1 of `mvi`.
- `dataOut` out DW: current bus value.
- `done` out 1: high during the final cycle of each instruction.

## Operation
- Instruction fields: opcode = `dataIn[DW-1:DW-3]`, Rx = next RW bits, Ry = following RW bits; remaining low bits are ignored.
- Opcodes:
  - 000 `mv`: Rx←Ry.
  - 001 `mvi`: Rx←dataIn.
  - 010 `add`: Rx←Rx+Ry.
  - 011 `sub`: Rx←Rx−Ry.
  - 100 `and`.
  - 101 `xor`.
  - 110 `mvnz`: Rx←Ry if Z==0.
  - 111 `nop`.
- State machine T0→T1→(T2→T3)→T0:
  - T0: bus=0. If Run, IR←dataIn and go to T1; otherwise stay in T0.
  - T1, `mv`/`mvnz`: bus=Ry. Rx←bus is unconditional for `mv`, gated by Z==0 for `mvnz`. done=1, go to T0.
  - T1, `mvi`: bus=dataIn, Rx←bus, done=1, go to T0.
  - T1, `nop`: bus=0, no writes, done=1, go to T0.
  - T1, ALU ops: bus=Rx, A←bus, go to T2.
  - T2: bus=Ry, G←A op bus, Z←(result==0), go to T3.
  - T3: bus=G, Rx←bus, done=1, go to T0.
- Arithmetic is modulo 2^DW; carry and borrow are discarded. `sub` is A + ~bus + 1.
- Only ALU ops write G and Z. `mv`, `mvi`, `mvnz` and `nop` leave Z unchanged.
- Exactly one bus source is active per cycle. With no source selected, the bus drives 0.
- Rx==Ry is legal. ALU ops read Rx in T1 and Ry in T2, so `sub R0,R0` yields 0.

## Timing
- Reset (async, any state, mid-instruction included):
  - state→T0
  - all registers, A, G and IR → 0
  - Z→1
  - done=0, dataOut=0
- Reset has no pending effects: a partially executed instruction is abandoned and no write occurs.
- Latency from Run-accept edge to done: 1 cycle for `mv`/`mvi`/`mvnz`/`nop`; 3 cycles for ALU ops. done is combinational from state and IR, high for exactly one cycle.
- Register writes take effect on the clock edge that ends the done cycle. A write is visible to the next instruction's first read.
- Run is ignored outside T0. Run held high gives back-to-back issue: the next instruction is captured in the T0 cycle right after done. There are no dead cycles beyond T0.
- The `mvi` immediate must be valid on dataIn during T1 (the cycle after capture).
- Rx/Ry field indices are always < NREG by construction, so there are no out-of-range cases.

## Configuration
- `CPU_LOGIC_OPS_EN` defined: opcodes 100/101 execute `and`/`xor` through T1–T3 like add/sub and update G and Z.
- `CPU_LOGIC_OPS_EN` undefined: opcodes 100/101 behave as `nop`. They complete in T1 with done=1 and write nothing; the AND/XOR ALU logic is not built.

## Test plan
- **Default params, immediate and move:** issue `mvi R0` (0x2000) with dataIn=0x0005 in T1, then `mv R1,R0` (0x0400) → done each in T1; dataOut=0x0005 in the mv T1 cycle.
- **ALU add latency:** issue `add R0,R1` (0x4080) → done exactly 3 cycles after the Run-accept edge; dataOut=0x000A in T3; Z=0.
- **Wrap and conditional move:**
  - `mvi R0,0xFFFF`; `mvi R1` (0x2400), dataIn=0x0001; `add R0,R1` → dataOut=0x0000 in T3, Z=1.
  - `mvnz R2,R1` (0xC880), then `mv R3,R2` (0x0D00) → dataOut=0x0000 in the mv T1 cycle (R2 not written).
- **Back-to-back issue:** hold Run=1 with a stream of `mv` instructions → one instruction retires every 2 cycles. Run pulsed during T2 → ignored; no extra capture.
- **Mid-operation reset:** drop resetn asynchronously in T2 of an `add` → done=0 and dataOut=0 immediately. After release, `mv R3,R0` shows dataOut=0x0000.
- **Macro off:** build without `CPU_LOGIC_OPS_EN`, issue opcode 100 → done in T1, no register change. Build with it: `and` of 0x00F0 and 0x0F0F → 0x0000, Z=1.

Source files
------------

// File: rtl/cpu_gen2.sv
// cpu_gen2 - parametrised multicycle bus CPU datapath and controller.
//
// Every instruction is captured in T0 and retires in T1 (moves, immediate,
// nop) or T3 (ALU ops). A single internal bus carries one source per cycle.
// That bus value is exported on dataOut.
//
// Parameters:
//   DW   - data/bus width (must satisfy DW >= 3 + 2*clog2(NREG))
//   NREG - register count, power of two, 2..16
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   resetn  - asynchronous active-low reset
//   Run     - instruction-valid strobe, only looked at in T0
//   dataIn  - instruction word in T0, immediate operand in T1 of mvi
//   dataOut - current bus value
//   done    - high during the final cycle of each instruction
//
// Build option:
//   CPU_LOGIC_OPS_EN - when defined, opcodes 100/101 execute and/xor through
//                      the ALU. When undefined they retire in T1 as a nop.
module cpu_gen2 #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          Run,
  input  logic [DW-1:0] dataIn,
  output logic [DW-1:0] dataOut,
  output logic          done
);

  localparam int RW  = $clog2(NREG);
  // Only the opcode and the two register fields of the instruction are kept.
  localparam int IRW = 3 + 2 * RW;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t          state;
  state_t          state_next;
  logic [IRW-1:0]  ir;
  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   a_reg;
  logic [DW-1:0]   g_reg;
  logic            z_flag;

  logic [2:0]      opcode;
  logic [RW-1:0]   rx;
  logic [RW-1:0]   ry;
  logic [DW-1:0]   bus;
  logic [DW-1:0]   alu_result;
  logic            rf_we;
  logic            a_en;
  logic            g_en;

  assign opcode  = ir[IRW-1 -: 3];
  assign rx      = ir[IRW-4 -: RW];
  assign ry      = ir[RW-1:0];
  assign dataOut = bus;

  // State, instruction, and datapath registers.
  // Reset clears everything and forces Z high. Any instruction in flight is
  // dropped without a write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= T0;
      ir     <= '0;
      a_reg  <= '0;
      g_reg  <= '0;
      z_flag <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (state == T0 && Run) begin
        ir <= dataIn[DW-1 -: IRW];
      end
      if (a_en) begin
        a_reg <= bus;
      end
      if (g_en) begin
        g_reg  <= alu_result;
        z_flag <= (alu_result == '0);
      end
      if (rf_we) begin
        regs[rx] <= bus;
      end
    end
  end

  // Controller: next state, bus source select, write enables and done.
  // When no case below selects a source, the bus stays at zero.
  always_comb begin
    state_next = state;
    bus        = '0;
    rf_we      = 1'b0;
    a_en       = 1'b0;
    g_en       = 1'b0;
    done       = 1'b0;
    case (state)
      T0: begin
        if (Run) begin
          state_next = T1;
        end
      end
      T1: begin
        state_next = T0;
        case (opcode)
          OP_MV: begin
            bus   = regs[ry];
            rf_we = 1'b1;
            done  = 1'b1;
          end
          OP_MVNZ: begin
            // The bus still shows Ry when the write is suppressed.
            bus   = regs[ry];
            rf_we = !z_flag;
            done  = 1'b1;
          end
          OP_MVI: begin
            bus   = dataIn;
            rf_we = 1'b1;
            done  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus        = regs[rx];
            a_en       = 1'b1;
            state_next = T2;
          end
`ifdef CPU_LOGIC_OPS_EN
          OP_AND, OP_XOR: begin
            bus        = regs[rx];
            a_en       = 1'b1;
            state_next = T2;
          end
`endif
          default: begin
            done = 1'b1;
          end
        endcase
      end
      T2: begin
        bus        = regs[ry];
        g_en       = 1'b1;
        state_next = T3;
      end
      T3: begin
        bus        = g_reg;
        rf_we      = 1'b1;
        done       = 1'b1;
        state_next = T0;
      end
      default: begin
        state_next = T0;
      end
    endcase
  end

  // ALU. It is only sampled in T2, so outside an ALU op its value is
  // don't-care. Carry and borrow are discarded.
  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_SUB:  alu_result = a_reg + ~bus + DW'(1);
`ifdef CPU_LOGIC_OPS_EN
      OP_AND:  alu_result = a_reg & bus;
      OP_XOR:  alu_result = a_reg ^ bus;
`endif
      default: alu_result = a_reg + bus;
    endcase
  end

endmodule
